// File: rtl/display_pkg.sv
// Shared definitions for the display pipeline: pixel layout and BCM scanner state encoding.
package display_pkg;

  localparam int unsigned PIXEL_BITS = 24;
  localparam int unsigned R_OFS      = 16;
  localparam int unsigned G_OFS      = 8;
  localparam int unsigned B_OFS      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DEAD,
    ST_DISPLAY,
    ST_NEXT
  } bcm_state_e;

endpackage

// File: rtl/display_bcm_timer.sv
// Loadable down-counter; expired_c is high once the loaded number of cycles has elapsed.
module display_bcm_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired_c
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Loading N makes expired_c rise in the N-th cycle after the load
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - WIDTH'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/display_bcm_scanner.sv
// Binary-code-modulation scan driver for a HUB75-style panel.
// Define DISPLAY_BCM_DEADTIME_EN to insert a blanking DEAD state between LATCH and DISPLAY.
module display_bcm_scanner
  import display_pkg::*;
#(
  parameter int unsigned segments     = 2,
  parameter int unsigned columns      = 64,
  parameter int unsigned rows         = 16,
  parameter int unsigned bits         = 8,
  parameter int unsigned latency      = 2,
  parameter int unsigned display_base = 1,
  parameter int unsigned deadtime     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  output logic                           req,
  output logic [$clog2(columns)-1:0]     req_col,
  output logic [$clog2(rows)-1:0]        req_row,
  input  logic [segments*PIXEL_BITS-1:0] cpixel,
  output logic [segments*3-1:0]          rgb,
  output logic                           sclk,
  output logic                           latch,
  output logic                           oe_n,
  output logic [$clog2(rows)-1:0]        row_sel,
  output logic                           frame_done
);

  localparam int unsigned COL_W      = $clog2(columns);
  localparam int unsigned ROW_W      = $clog2(rows);
  localparam int unsigned PLANE_W    = (bits > 1) ? $clog2(bits) : 1;
  localparam int unsigned SHIFT_LAST = 2 * columns + latency;
  localparam int unsigned PH_W       = $clog2(SHIFT_LAST + 1);
  localparam int unsigned SHOW_MAX   = display_base << (bits - 1);
  localparam int unsigned TMR_MAX    = (SHOW_MAX > deadtime) ? SHOW_MAX : deadtime;
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
  localparam logic        LAT_ODD    = 1'(latency % 2);

  bcm_state_e                state_q, state_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [PLANE_W-1:0]        plane_q, plane_d, nxt_plane;
  logic [ROW_W-1:0]          row_q, row_d, nxt_row;
  logic                      cont_q, cont_d;
  logic                      req_q, req_d;
  logic [COL_W-1:0]          req_col_q, req_col_d;
  logic [ROW_W-1:0]          req_row_q, req_row_d;
  logic [segments*3-1:0]     rgb_q, rgb_d;
  logic                      sclk_q, sclk_d;
  logic                      latch_q, latch_d;
  logic                      oe_n_q, oe_n_d;
  logic [ROW_W-1:0]          row_sel_q, row_sel_d;
  logic                      frame_done_q, frame_done_d;

  logic                      last_plane, last_row, sample;
  logic [PIXEL_BITS-1:0]     pix;
  logic                      tmr_load, tmr_expired_c;
  logic [TMR_W-1:0]          tmr_val, show_len;

  assign last_plane = (plane_q == PLANE_W'(bits - 1));
  assign last_row   = (row_q == ROW_W'(rows - 1));
  assign nxt_plane  = last_plane ? '0 : plane_q + PLANE_W'(1);
  assign nxt_row    = last_plane ? (last_row ? '0 : row_q + ROW_W'(1)) : row_q;
  assign show_len   = TMR_W'(display_base) << plane_q;

  display_bcm_timer #(.WIDTH(TMR_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expired_c (tmr_expired_c)
  );

  // phase counts cycles since the plane's column-0 request: 0 in NEXT (or first SHIFT cycle from IDLE)
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    plane_d  = plane_q;
    row_d    = row_q;
    cont_d   = cont_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SHIFT;
          phase_d = '0;
        end
      end
      ST_SHIFT: begin
        if (phase_q == PH_W'(SHIFT_LAST)) begin
          state_d = ST_LATCH;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_LATCH: begin
        tmr_load = 1'b1;
`ifdef DISPLAY_BCM_DEADTIME_EN
        state_d = ST_DEAD;
        tmr_val = TMR_W'(deadtime);
`else
        state_d = ST_DISPLAY;
        tmr_val = show_len;
`endif
      end
      ST_DEAD: begin
        if (tmr_expired_c) begin
          state_d  = ST_DISPLAY;
          tmr_load = 1'b1;
          tmr_val  = show_len;
        end
      end
      ST_DISPLAY: begin
        // en is only consulted as the final display of a frame expires
        if (tmr_expired_c) begin
          state_d = ST_NEXT;
          phase_d = '0;
          cont_d  = en || !(last_plane && last_row);
        end
      end
      ST_NEXT: begin
        plane_d = nxt_plane;
        row_d   = nxt_row;
        phase_d = PH_W'(1);
        state_d = cont_q ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_d     = 1'b0;
    req_col_d = req_col_q;
    req_row_d = req_row_q;
    if ((state_d == ST_SHIFT || (state_d == ST_NEXT && cont_d)) &&
        !phase_d[0] && phase_d < PH_W'(2 * columns)) begin
      req_d     = 1'b1;
      req_col_d = COL_W'(phase_d >> 1);
      req_row_d = (state_d == ST_NEXT) ? nxt_row : row_d;
    end

    // cpixel for a request made at phase p arrives at phase p+latency
    sample = (state_q == ST_SHIFT || state_q == ST_NEXT) &&
             phase_q >= PH_W'(latency) && phase_q[0] == LAT_ODD &&
             phase_q < PH_W'(SHIFT_LAST);
    pix    = '0;
    rgb_d  = rgb_q;
    if (sample) begin
      for (int s = 0; s < int'(segments); s++) begin
        pix = cpixel[s*PIXEL_BITS +: PIXEL_BITS];
        rgb_d[s*3 +: 3] = {1'(pix >> (B_OFS + 32'(plane_d))),
                           1'(pix >> (G_OFS + 32'(plane_d))),
                           1'(pix >> (R_OFS + 32'(plane_d)))};
      end
    end

    sclk_d       = (state_d == ST_SHIFT) && phase_d >= PH_W'(latency + 2) &&
                   phase_d[0] == LAT_ODD;
    latch_d      = (state_d == ST_LATCH);
    oe_n_d       = (state_d != ST_DISPLAY);
    row_sel_d    = (state_d == ST_LATCH) ? row_d : row_sel_q;
    frame_done_d = (state_d == ST_NEXT) && last_plane && last_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      plane_q      <= '0;
      row_q        <= '0;
      cont_q       <= 1'b0;
      req_q        <= 1'b0;
      req_col_q    <= '0;
      req_row_q    <= '0;
      rgb_q        <= '0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      row_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      cont_q       <= cont_d;
      req_q        <= req_d;
      req_col_q    <= req_col_d;
      req_row_q    <= req_row_d;
      rgb_q        <= rgb_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      row_sel_q    <= row_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign req        = req_q;
  assign req_col    = req_col_q;
  assign req_row    = req_row_q;
  assign rgb        = rgb_q;
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign oe_n       = oe_n_q;
  assign row_sel    = row_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_bcm_scanner.sv
// Bench for display_bcm_scanner: encoder modelled as a fixed-latency lookup of {row, col},
// panel behaviour checked against scan-order, weighting and framing rules.
module tb_display_bcm_scanner;

  localparam int SEG   = 2;
  localparam int C     = 4;
  localparam int ROWS  = 2;
  localparam int BITS  = 2;
  localparam int LAT   = 2;
  localparam int BASE  = 1;
  localparam int DTIME = 4;
  localparam int CW    = $clog2(C);
  localparam int RW    = $clog2(ROWS);
`ifdef DISPLAY_BCM_DEADTIME_EN
  localparam int DT = DTIME;
`else
  localparam int DT = 0;
`endif

  typedef struct packed {
    logic          v;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } enc_t;

  logic              clk, rst, en;
  logic              req, sclk, latch, oe_n, frame_done;
  logic [CW-1:0]     req_col;
  logic [RW-1:0]     req_row, row_sel;
  logic [SEG*24-1:0] cpixel;
  logic [SEG*3-1:0]  rgb;

  display_bcm_scanner #(
    .segments(SEG), .columns(C), .rows(ROWS), .bits(BITS),
    .latency(LAT), .display_base(BASE), .deadtime(DTIME)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_col(req_col), .req_row(req_row),
    .cpixel(cpixel), .rgb(rgb), .sclk(sclk), .latch(latch), .oe_n(oe_n),
    .row_sel(row_sel), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SEG*24-1:0] img [ROWS][C];
  enc_t              pipe [LAT+1];

  int n_cmp, n_err;
  int cyc, req_n, sh_n, latch_n, disp_n, sclk_cnt, run_len, since_latch;
  int last_latch_cyc, latch_plane;
  bit stopped, fd_seen;
  logic prev_sclk, prev_oe_n, prev_fd;
  logic [RW-1:0]    prev_row_sel;
  logic [SEG*3-1:0] prev_rgb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Panel bits for plane b of a pixel: per segment {B, G, R}
  function automatic logic [SEG*3-1:0] exp_rgb(input logic [SEG*24-1:0] px, input int b);
    logic [SEG*24-1:0] t;
    logic [SEG*3-1:0]  v;
    v = '0;
    for (int s = 0; s < SEG; s++) begin
      t = px >> (s*24 + 16 + b);
      v = v | ((SEG*3)'(t[0]) << (s*3));
      t = px >> (s*24 + 8 + b);
      v = v | ((SEG*3)'(t[0]) << (s*3 + 1));
      t = px >> (s*24 + b);
      v = v | ((SEG*3)'(t[0]) << (s*3 + 2));
    end
    return v;
  endfunction

  task automatic clear_model();
    req_n = 0; sh_n = 0; latch_n = 0; disp_n = 0; sclk_cnt = 0;
    run_len = 0; since_latch = 0; latch_plane = 0; last_latch_cyc = 0;
    for (int k = 0; k <= LAT; k++) pipe[k] = '0;
  endtask

  // One clock: advance the encoder model, then check the cycle's outputs
  task automatic cycle();
    int g, c, r, b;
    logic [SEG*3-1:0] e;
    @(posedge clk);
    #1;
    for (int k = LAT; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = '{v: req, r: req_row, c: req_col};
    if (pipe[LAT].v) cpixel = img[pipe[LAT].r][pipe[LAT].c];
    else             cpixel = (SEG*24)'({$urandom(), $urandom()});

    if (rst) begin
      chk("reset_outputs",
          64'({req, req_col, req_row, rgb, sclk, latch, oe_n, row_sel, frame_done}),
          64'({1'b0, CW'(0), RW'(0), (SEG*3)'(0), 1'b0, 1'b0, 1'b1, RW'(0), 1'b0}));
      clear_model();
    end else begin
      cyc++;
      if (req) begin
        g = req_n / C;
        chk("req_col", 64'(req_col), 64'(req_n % C));
        chk("req_row", 64'(req_row), 64'((g / BITS) % ROWS));
        req_n++;
      end
      if (sclk && !prev_sclk) begin
        g = sh_n / C; c = sh_n % C; b = g % BITS; r = (g / BITS) % ROWS;
        e = exp_rgb(img[r][c], b);
        chk("rgb_shift", 64'(rgb), 64'(e));
        chk("rgb_setup", 64'(prev_rgb), 64'(e));
        sh_n++; sclk_cnt++;
      end
      if (latch) begin
        chk("latch_oe_n", 64'(oe_n), 64'(1));
        chk("sclk_per_plane", 64'(sclk_cnt), 64'(C));
        chk("row_sel", 64'(row_sel), 64'((latch_n / BITS) % ROWS));
        if (latch_n % (BITS*ROWS) != 0)
          chk("plane_period", 64'(cyc - last_latch_cyc),
              64'(2*C + LAT + DT + (BASE << ((latch_n - 1) % BITS)) + 2));
        last_latch_cyc = cyc; latch_plane = latch_n % BITS;
        latch_n++; sclk_cnt = 0; since_latch = 0;
      end else begin
        since_latch++;
      end
      if (!oe_n) begin
        if (prev_oe_n) chk("latch_to_display", 64'(since_latch), 64'(DT + 1));
        run_len++;
      end else if (!prev_oe_n) begin
        chk("display_len", 64'(run_len), 64'(BASE << latch_plane));
        disp_n++; run_len = 0;
      end
      if (frame_done) begin
        chk("frame_done_pos", 64'(disp_n > 0 && disp_n % (BITS*ROWS) == 0 && !prev_oe_n && !prev_fd), 64'(1));
        fd_seen = 1'b1;
        if (!en) stopped = 1'b1;
      end
      chk("blank_guard", 64'((!oe_n && (latch || row_sel != prev_row_sel)) || (sclk && (latch || !oe_n))), 64'(0));
      if (stopped) begin
        chk("idle_req", 64'(req), 64'(0));
        chk("idle_oe_n", 64'(oe_n), 64'(1));
      end
    end
    prev_sclk = sclk; prev_oe_n = oe_n; prev_fd = frame_done;
    prev_row_sel = row_sel; prev_rgb = rgb;
  endtask

  task automatic wait_frames(input int n);
    int got;
    got = 0;
    for (int i = 0; i < 400 * n && got < n; i++) begin
      fd_seen = 1'b0;
      cycle();
      if (fd_seen) got++;
    end
    chk("frame_wait", 64'(got), 64'(n));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; stopped = 1'b0; fd_seen = 1'b0;
    prev_sclk = 1'b0; prev_oe_n = 1'b1; prev_fd = 1'b0; prev_row_sel = '0; prev_rgb = '0;
    clear_model();
    rst = 1'b1; en = 1'b1; cpixel = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < C; c++) img[r][c] = {24'h000000, 24'hff00ff};

    // reset held two cycles with en high
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("first_req", 64'(req), 64'(1));
    chk("fixed_rgb_plane0", 64'(exp_rgb(img[0][0], 0)), 64'(6'b000101));
    wait_frames(2);

    // mid-operation reset, then random image
    repeat ($urandom_range(40, 5)) cycle();
    rst = 1'b1;
    cycle();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < C; c++) img[r][c] = (SEG*24)'({$urandom(), $urandom()});
    rst = 1'b0;
    cycle();
    chk("first_req_after_reset", 64'(req), 64'(1));
    wait_frames(2);

    // drop en mid-frame: the frame completes, then the scanner idles
    repeat ($urandom_range(40, 10)) cycle();
    en = 1'b0;
    wait_frames(1);
    chk("stopped_after_frame", 64'(stopped), 64'(1));
    repeat (60) cycle();

    // restart
    en = 1'b1;
    stopped = 1'b0;
    wait_frames(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
